// File: rtl/vga_pkg.sv
// Shared VGA timing types and the default 640x480@60 timing set.
package vga_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned MAX_TOTAL   = 1 << COORD_W;

  typedef struct packed {
    logic [COORD_W-1:0] h_active;
    logic [COORD_W-1:0] h_fp;
    logic [COORD_W-1:0] h_sync;
    logic [COORD_W-1:0] h_bp;
    logic [COORD_W-1:0] v_active;
    logic [COORD_W-1:0] v_fp;
    logic [COORD_W-1:0] v_sync;
    logic [COORD_W-1:0] v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    h_active: COORD_W'(640),
    h_fp:     COORD_W'(16),
    h_sync:   COORD_W'(96),
    h_bp:     COORD_W'(48),
    v_active: COORD_W'(480),
    v_fp:     COORD_W'(10),
    v_sync:   COORD_W'(2),
    v_bp:     COORD_W'(33)
  };

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-enable strobe generator: one-cycle pix_tick every DIV_RATIO clk_in cycles.
module vga_pix_tick #(
  parameter int unsigned DIV_RATIO = 2
) (
  input  logic clk_in,
  input  logic reset,
  output logic pix_tick
);

  localparam int unsigned     DIV_W    = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_RATIO - 1);

  if (DIV_RATIO == 0) begin : g_div_ratio_chk
    $error("vga_pix_tick: DIV_RATIO must be at least 1");
  end

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_tick_q, pix_tick_d;

  // The strobe is registered so it is high in the cycle where div_cnt sits at its last value.
  always_comb begin
    div_cnt_d  = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    pix_tick_d = (div_cnt_d == DIV_LAST);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_cnt_q  <= '0;
      pix_tick_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      pix_tick_q <= pix_tick_d;
    end
  end

  assign pix_tick = pix_tick_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: h/v counters and sync/active decode, all qualified by pix_tick.
// Optional frame counter output enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned DIV_RATIO = 2,
  parameter int unsigned H_ACTIVE  = 32'(VGA_640X480_60.h_active),
  parameter int unsigned H_FP      = 32'(VGA_640X480_60.h_fp),
  parameter int unsigned H_SYNC    = 32'(VGA_640X480_60.h_sync),
  parameter int unsigned H_BP      = 32'(VGA_640X480_60.h_bp),
  parameter int unsigned V_ACTIVE  = 32'(VGA_640X480_60.v_active),
  parameter int unsigned V_FP      = 32'(VGA_640X480_60.v_fp),
  parameter int unsigned V_SYNC    = 32'(VGA_640X480_60.v_sync),
  parameter int unsigned V_BP      = 32'(VGA_640X480_60.v_bp)
) (
  input  logic               clk_in,
  input  logic               reset,
  output logic               pix_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_count
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned CMP_W   = COORD_W + 1;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  // One extra bit so a sync window ending exactly at 2^COORD_W still compares correctly.
  localparam logic [CMP_W-1:0] H_VIS_END = CMP_W'(H_ACTIVE);
  localparam logic [CMP_W-1:0] HS_START  = CMP_W'(H_ACTIVE + H_FP);
  localparam logic [CMP_W-1:0] HS_END    = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CMP_W-1:0] V_VIS_END = CMP_W'(V_ACTIVE);
  localparam logic [CMP_W-1:0] VS_START  = CMP_W'(V_ACTIVE + V_FP);
  localparam logic [CMP_W-1:0] VS_END    = CMP_W'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > MAX_TOTAL) begin : g_h_total_chk
    $error("vga_timing_ctrl: H_TOTAL exceeds counter range");
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_v_total_chk
    $error("vga_timing_ctrl: V_TOTAL exceeds counter range");
  end

  vga_pix_tick #(
    .DIV_RATIO (DIV_RATIO)
  ) u_pix_tick (
    .clk_in   (clk_in),
    .reset    (reset),
    .pix_tick (pix_tick)
  );

  logic [COORD_W-1:0] h_count_q, h_count_d;
  logic [COORD_W-1:0] v_count_q, v_count_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               video_on_q, video_on_d;
  logic               frame_start_q, frame_start_d;
  logic               wrap_c;
  logic [CMP_W-1:0]   h_cmp_c, v_cmp_c;

`ifdef VGA_FRAME_COUNT_EN
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
`endif

  // Next raster position, then decode outputs from it so they describe the new position.
  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    wrap_c    = 1'b0;

    if (pix_tick) begin
      if (h_count_q == H_LAST) begin
        h_count_d = '0;
        if (v_count_q == V_LAST) begin
          v_count_d = '0;
          wrap_c    = 1'b1;
        end else begin
          v_count_d = v_count_q + 1'b1;
        end
      end else begin
        h_count_d = h_count_q + 1'b1;
      end
    end

    h_cmp_c       = {1'b0, h_count_d};
    v_cmp_c       = {1'b0, v_count_d};
    hsync_d       = !((h_cmp_c >= HS_START) && (h_cmp_c < HS_END));
    vsync_d       = !((v_cmp_c >= VS_START) && (v_cmp_c < VS_END));
    video_on_d    = (h_cmp_c < H_VIS_END) && (v_cmp_c < V_VIS_END);
    frame_start_d = wrap_c;
  end

`ifdef VGA_FRAME_COUNT_EN
  always_comb begin
    frame_count_d = frame_count_q;
    if (wrap_c) begin
      frame_count_d = frame_count_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk_in) begin
    if (reset) begin
      h_count_q     <= '0;
      v_count_q     <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VGA_FRAME_COUNT_EN
      frame_count_q <= '0;
`endif
    end else begin
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_FRAME_COUNT_EN
      frame_count_q <= frame_count_d;
`endif
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = h_count_q;
  assign pixel_y     = v_count_q;
  assign frame_start = frame_start_q;
`ifdef VGA_FRAME_COUNT_EN
  assign frame_count = frame_count_q;
`endif

endmodule
